// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mem_seq_state_t;

  localparam int MEM_LATENCY_DEFAULT = 2;
  localparam int MEM_ADDR_W          = 32;
  localparam int MEM_DATA_W          = 32;

endpackage

// File: rtl/mem_wait_counter.sv
// 4-bit loadable down-counter that times out the memory latency.
module mem_wait_counter (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_value,
  output logic [3:0] count,
  output logic       last
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != 4'd0)) begin
      // Saturates at zero; only reachable if the FSM misbehaves.
      count <= count - 4'd1;
    end
  end

  assign last = (count == 4'd1);

endmodule

// File: rtl/mem_access_seq.sv
// Sequences one word-aligned load/store at a time against a fixed-latency
// synchronous memory and returns a one-cycle response with the MDR contents.
//
// Handshake: a request is taken on a rising edge where ReqValid=1 and
// ReqReady=1; ReqValid while ReqReady=0 is ignored. RespValid is a single
// cycle pulse with no back-pressure, qualified by RespErr.
module mem_access_seq
  import mem_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqValid,
  input  logic                  ReqWrite,
  input  logic [MEM_ADDR_W-1:0] ReqAddr,
  input  logic [MEM_DATA_W-1:0] ReqWData,
  output logic                  ReqReady,
  output logic                  Busy,
  output logic                  RespValid,
  output logic                  RespErr,
  output logic [MEM_DATA_W-1:0] RespRData,
  output logic [MEM_ADDR_W-1:0] MemAddr,
  output logic [MEM_DATA_W-1:0] MemWData,
  output logic                  MemWr,
  input  logic [MEM_DATA_W-1:0] MemRData,
  output logic [1:0]            state_dbg,
  output logic [3:0]            wait_count_dbg
);

  mem_seq_state_t        state, state_nxt;
  logic                  wr_q;
  logic                  err_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [MEM_DATA_W-1:0] wdata_q;
  logic [MEM_DATA_W-1:0] mdr_q;

  logic cnt_load, cnt_dec, cnt_last;
  logic accept, reject, capture;

  mem_wait_counter u_wait_counter (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (4'(LATENCY - 1)),
    .count      (wait_count_dbg),
    .last       (cnt_last)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ReqValid) begin
          if (ReqAddr[1:0] != 2'b00) begin
            reject    = 1'b1;
            state_nxt = DONE;
          end else begin
            accept    = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (LATENCY == 1) begin
          capture   = !wr_q;
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          capture   = !wr_q;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Misaligned requests leave the memory-side registers and MDR untouched.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
    end else begin
      if (accept) begin
        wr_q    <= ReqWrite;
        addr_q  <= ReqAddr;
        wdata_q <= ReqWData;
      end
      if (reject) begin
        err_q <= 1'b1;
      end else if (state == DONE) begin
        err_q <= 1'b0;
      end
      if (capture) begin
        mdr_q <= MemRData;
      end
    end
  end

  assign ReqReady  = (state == IDLE);
  assign Busy      = !ReqReady;
  assign RespValid = (state == DONE);
  assign RespErr   = err_q;
  assign RespRData = mdr_q;
  assign MemAddr   = addr_q;
  assign MemWData  = wdata_q;
  // Decoded from registered state so an asynchronous reset drops it at once.
  assign MemWr     = (state == ISSUE) && wr_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: one instance at LATENCY=2 and one at LATENCY=1
// share stimulus; a cycle-count model predicts outputs for both.
module tb_mem_access_seq;

  logic        Clk;
  logic        Reset;
  logic        ReqValid;
  logic        ReqWrite;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;

  logic        req_ready  [2];
  logic        busy       [2];
  logic        resp_valid [2];
  logic        resp_err   [2];
  logic [31:0] resp_rdata [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic        mem_wr     [2];
  logic [31:0] mem_rdata  [2];
  logic [1:0]  state_dbg  [2];
  logic [3:0]  wcnt_dbg   [2];

  int lat [2];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] memfun(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- DUTs and memory models ----------------
  mem_access_seq #(.LATENCY(2)) dut0 (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqReady(req_ready[0]),
    .Busy(busy[0]), .RespValid(resp_valid[0]), .RespErr(resp_err[0]),
    .RespRData(resp_rdata[0]), .MemAddr(mem_addr[0]), .MemWData(mem_wdata[0]),
    .MemWr(mem_wr[0]), .MemRData(mem_rdata[0]), .state_dbg(state_dbg[0]),
    .wait_count_dbg(wcnt_dbg[0])
  );

  mem_access_seq #(.LATENCY(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqReady(req_ready[1]),
    .Busy(busy[1]), .RespValid(resp_valid[1]), .RespErr(resp_err[1]),
    .RespRData(resp_rdata[1]), .MemAddr(mem_addr[1]), .MemWData(mem_wdata[1]),
    .MemWr(mem_wr[1]), .MemRData(mem_rdata[1]), .state_dbg(state_dbg[1]),
    .wait_count_dbg(wcnt_dbg[1])
  );

  // Latency-2 memory: one register stage; latency-1 memory: combinational.
  always @(posedge Clk) mem_rdata[0] <= memfun(mem_addr[0]);
  assign mem_rdata[1] = memfun(mem_addr[1]);

  // ---------------- behavioural model ----------------
  // t counts cycles since acceptance (0 = idle); the response is in cycle
  // t == L+1, a store writes in t == 1, load data is sampled at t == L.
  typedef struct {
    int          t;
    bit          err;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdr;
  } model_t;

  model_t      m [2];
  logic [31:0] exp_q[$];

  initial begin
    lat[0] = 2;
    lat[1] = 1;
  end

  always @(posedge Clk or posedge Reset) begin
    for (int d = 0; d < 2; d++) begin
      if (Reset) begin
        m[d].t = 0; m[d].err = 0; m[d].wr = 0;
        m[d].addr = '0; m[d].wdata = '0; m[d].mdr = '0;
      end else if (m[d].t == 0) begin
        if (ReqValid) begin
          if (ReqAddr[1:0] != 2'b00) begin
            m[d].t   = lat[d] + 1;
            m[d].err = 1;
          end else begin
            m[d].t     = 1;
            m[d].err   = 0;
            m[d].wr    = ReqWrite;
            m[d].addr  = ReqAddr;
            m[d].wdata = ReqWData;
            if (d == 0 && !ReqWrite) exp_q.push_back(memfun(ReqAddr));
          end
        end
      end else if (m[d].t == lat[d] + 1) begin
        m[d].t   = 0;
        m[d].err = 0;
      end else begin
        if (m[d].t == lat[d] && !m[d].wr) m[d].mdr = memfun(m[d].addr);
        m[d].t = m[d].t + 1;
      end
    end
    if (Reset) exp_q.delete();
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      for (int d = 0; d < 2; d++) begin
        logic rv;
        rv = (m[d].t == lat[d] + 1);
        chk($sformatf("d%0d ReqReady", d), 32'(req_ready[d]), 32'(m[d].t == 0));
        chk($sformatf("d%0d Busy", d), 32'(busy[d]), 32'(m[d].t != 0));
        chk($sformatf("d%0d RespValid", d), 32'(resp_valid[d]), 32'(rv));
        chk($sformatf("d%0d RespErr", d), 32'(resp_err[d]), 32'(rv && m[d].err));
        chk($sformatf("d%0d MemWr", d), 32'(mem_wr[d]), 32'(m[d].t == 1 && m[d].wr));
        chk($sformatf("d%0d MemAddr", d), mem_addr[d], m[d].addr);
        chk($sformatf("d%0d MemWData", d), mem_wdata[d], m[d].wdata);
        chk($sformatf("d%0d RespRData", d), resp_rdata[d], m[d].mdr);
        if (d == 0 && rv && !m[d].err && !m[d].wr) begin
          if (exp_q.size() == 0) begin
            chk("d0 resp queue empty", 32'd1, 32'd0);
          end else begin
            chk("d0 resp data", resp_rdata[0], exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] wd);
    ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqWData = wd;
  endtask

  task automatic idle();
    ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // ---------------- directed stimulus ----------------
  int rv0, rv1;

  initial begin
    Reset = 1'b1;
    idle();
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("rst ReqReady", 32'(req_ready[d]), 32'd1);
      chk("rst Busy", 32'(busy[d]), 32'd0);
      chk("rst RespValid", 32'(resp_valid[d]), 32'd0);
      chk("rst RespErr", 32'(resp_err[d]), 32'd0);
      chk("rst MemWr", 32'(mem_wr[d]), 32'd0);
      chk("rst MemAddr", mem_addr[d], 32'd0);
      chk("rst MemWData", mem_wdata[d], 32'd0);
      chk("rst RespRData", resp_rdata[d], 32'd0);
      chk("rst state", 32'(state_dbg[d]), 32'd0);
      chk("rst counter", 32'(wcnt_dbg[d]), 32'd0);
    end
    @(negedge Clk) Reset = 1'b0;
    cycles(2);

    // Aligned load of 0x10 in cycle k
    req(1'b0, 32'h10, 32'h0);
    cycles(1); idle();
    chk("ld MemAddr k+1", mem_addr[0], 32'h10);
    chk("ld MemWr k+1", 32'(mem_wr[0]), 32'd0);
    chk("ld Busy k+1", 32'(busy[0]), 32'd1);
    chk("ld state ISSUE", 32'(state_dbg[0]), 32'd1);
    cycles(1);
    chk("ld L1 RespValid k+2", 32'(resp_valid[1]), 32'd1);
    chk("ld L1 RespRData k+2", resp_rdata[1], 32'hDEADBEEF);
    chk("ld L2 RespValid k+2", 32'(resp_valid[0]), 32'd0);
    cycles(1);
    chk("ld RespValid k+3", 32'(resp_valid[0]), 32'd1);
    chk("ld RespRData k+3", resp_rdata[0], 32'hDEADBEEF);
    chk("ld RespErr k+3", 32'(resp_err[0]), 32'd0);
    cycles(1);
    chk("ld ReqReady k+4", 32'(req_ready[0]), 32'd1);
    cycles(2);

    // Aligned store
    req(1'b1, 32'h20, 32'h12345678);
    cycles(1); idle();
    chk("st MemWr k+1", 32'(mem_wr[0]), 32'd1);
    chk("st MemAddr k+1", mem_addr[0], 32'h20);
    chk("st MemWData k+1", mem_wdata[0], 32'h12345678);
    cycles(1);
    chk("st MemWr k+2", 32'(mem_wr[0]), 32'd0);
    cycles(1);
    chk("st RespValid k+3", 32'(resp_valid[0]), 32'd1);
    chk("st MDR kept", resp_rdata[0], 32'hDEADBEEF);
    cycles(2);

    // Misaligned
    req(1'b0, 32'h22, 32'h0);
    cycles(1); idle();
    chk("mis RespValid", 32'(resp_valid[0]), 32'd1);
    chk("mis RespErr", 32'(resp_err[0]), 32'd1);
    chk("mis L1 RespErr", 32'(resp_err[1]), 32'd1);
    chk("mis MemWr", 32'(mem_wr[0]), 32'd0);
    chk("mis MemAddr kept", mem_addr[0], 32'h20);
    chk("mis MDR kept", resp_rdata[0], 32'hDEADBEEF);
    cycles(1);
    chk("mis ReqReady k+2", 32'(req_ready[0]), 32'd1);
    chk("mis RespErr clr", 32'(resp_err[0]), 32'd0);
    cycles(2);

    // Back-to-back with ReqValid held high, address flipping every 4 cycles
    rv0 = 0; rv1 = 0;
    for (int i = 0; i < 16; i++) begin
      req(1'b0, (((i / 4) % 2) != 0) ? 32'h4 : 32'h0, 32'h0);
      cycles(1);
      if (resp_valid[0]) rv0++;
      if (resp_valid[1]) rv1++;
    end
    idle();
    chk("b2b L2 responses", 32'(rv0), 32'd4);
    chk("b2b L1 responses", 32'(rv1), 32'd5);
    cycles(6);
    chk("b2b last MDR", resp_rdata[0], 32'h0004FFFB);

    // Reset during WAIT
    req(1'b0, 32'h8, 32'h0);
    cycles(1); idle();
    cycles(1);
    chk("abort state WAIT", 32'(state_dbg[0]), 32'd2);
    #2 Reset = 1'b1;
    #1;
    chk("abort state IDLE", 32'(state_dbg[0]), 32'd0);
    chk("abort ReqReady", 32'(req_ready[0]), 32'd1);
    chk("abort RespValid", 32'(resp_valid[0]), 32'd0);
    chk("abort MDR cleared", resp_rdata[0], 32'd0);
    chk("abort MemWr", 32'(mem_wr[0]), 32'd0);
    @(negedge Clk) Reset = 1'b0;
    rv0 = 0;
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      if (resp_valid[0]) rv0++;
    end
    chk("abort no response", 32'(rv0), 32'd0);

    // Reset while a store is in ISSUE
    req(1'b1, 32'h30, 32'hCAFEF00D);
    cycles(1); idle();
    chk("st-abort MemWr before", 32'(mem_wr[0]), 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("st-abort MemWr L2", 32'(mem_wr[0]), 32'd0);
    chk("st-abort MemWr L1", 32'(mem_wr[1]), 32'd0);
    @(negedge Clk) Reset = 1'b0;
    cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
